clean_ctrl: RTL and testbench

CLEAN_CTRL -- requirements
Module: clean_ctrl

---
 rtl/hood_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/clean_ctrl.sv | 147 ++++++++++++++
 tb/tb_clean_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// Shared definitions for the range-hood controller.
//   hood_state_e : FSM state encoding (OFF=0, ON=1, CLEAN=2, FINISH=3)
//   DEF_*        : default timing constants used as parameter defaults
//   cnt_width    : width helper for counters that must hold 0..n-1
package hood_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_ON     = 2'd1,
        ST_CLEAN  = 2'd2,
        ST_FINISH = 2'd3
    } hood_state_e;

    localparam int DEF_CLK_HZ       = 100000000;
    localparam int DEF_DEBOUNCE_CYC = 2000000;
    localparam int DEF_DONE_HOLD_S  = 3;
    localparam int DEF_REMIND_S     = 36000;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   btn   : raw asynchronous button level
//   press : one-cycle pulse when a new high level has been accepted
module btn_debounce
    import hood_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYC);

    logic          meta;
    logic          sync;
    logic          level;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles the synchronised input has disagreed
    // with the accepted level; any return to agreement restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            meta  <= btn;
            sync  <= meta;
            press <= 1'b0;
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level <= sync;
                cnt   <= '0;
                press <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clean_ctrl.sv
// Range-hood power / self-clean controller.
//   clk, rst                : system clock, asynchronous active-low reset
//   btn_power, btn_clean    : raw buttons (debounced internally)
//   fan_active              : fan running at any speed
//   clean_done              : completion level from the self-clean timer
//   is_on, start_clean,
//   clean_finished, remind  : registered status outputs
//   state                   : current FSM state code
//
// state  | meaning
// OFF    | hood unpowered, waiting for power press
// ON     | powered, fan may run, usage accumulates
// CLEAN  | self-clean requested, waiting for clean_done
// FINISH | clean complete indication, held DONE_HOLD_S seconds
module clean_ctrl
    import hood_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int DONE_HOLD_S  = DEF_DONE_HOLD_S,
    parameter int REMIND_S     = DEF_REMIND_S
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_power,
    input  logic       btn_clean,
    input  logic       fan_active,
    input  logic       clean_done,
    output logic       is_on,
    output logic       start_clean,
    output logic       clean_finished,
    output logic       remind,
    output logic [1:0] state
);

    localparam int HOLD_CYC = DONE_HOLD_S * CLK_HZ;

    logic        pwr_press;
    logic        cln_press;
    hood_state_e st;
    logic [31:0] div;
    logic        tick;
    logic [31:0] hold;
    logic [15:0] usage;
    logic        fin_entry;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_power (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_power),
        .press (pwr_press)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clean (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_clean),
        .press (cln_press)
    );

    assign tick      = (div == 32'(CLK_HZ - 1));
    // A power press on the same cycle as clean_done wins, so no FINISH entry.
    assign fin_entry = (st == ST_CLEAN) && clean_done && !pwr_press;
    assign state     = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (fin_entry || tick) begin
            div <= '0;
        end else begin
            div <= div + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            usage  <= '0;
            remind <= 1'b0;
        end else if (fin_entry) begin
            usage  <= '0;
            remind <= 1'b0;
        end else if (tick && (st == ST_ON) && fan_active && (usage != 16'(REMIND_S))) begin
            usage  <= usage + 16'd1;
            remind <= ((usage + 16'd1) == 16'(REMIND_S));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st             <= ST_OFF;
            hold           <= '0;
            is_on          <= 1'b0;
            start_clean    <= 1'b0;
            clean_finished <= 1'b0;
        end else begin
            case (st)
                ST_OFF: begin
                    if (pwr_press) begin
                        st    <= ST_ON;
                        is_on <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (pwr_press) begin
                        st    <= ST_OFF;
                        is_on <= 1'b0;
                    end else if (cln_press && !fan_active) begin
                        st          <= ST_CLEAN;
                        start_clean <= 1'b1;
                    end
                end
                ST_CLEAN: begin
                    if (pwr_press) begin
                        st          <= ST_OFF;
                        is_on       <= 1'b0;
                        start_clean <= 1'b0;
                    end else if (clean_done) begin
                        st             <= ST_FINISH;
                        hold           <= '0;
                        start_clean    <= 1'b0;
                        clean_finished <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    if (pwr_press) begin
                        st             <= ST_OFF;
                        is_on          <= 1'b0;
                        clean_finished <= 1'b0;
                    end else if (hold == 32'(HOLD_CYC - 1)) begin
                        st             <= ST_ON;
                        clean_finished <= 1'b0;
                    end else begin
                        hold <= hold + 32'd1;
                    end
                end
                default: begin
                    st             <= ST_OFF;
                    is_on          <= 1'b0;
                    start_clean    <= 1'b0;
                    clean_finished <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clean_ctrl.sv
// Self-checking bench for clean_ctrl with small timing parameters.
module tb_clean_ctrl;

    localparam int CLK_HZ   = 10;
    localparam int DEB      = 4;
    localparam int HOLD_S   = 2;
    localparam int REMIND   = 5;
    localparam int HOLD_CYC = HOLD_S * CLK_HZ;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_power;
    logic       btn_clean;
    logic       fan_active;
    logic       clean_done;
    logic       is_on;
    logic       start_clean;
    logic       clean_finished;
    logic       remind;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;
    int m_st   = 0;
    int lat    = 7;

    clean_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_CYC(DEB),
        .DONE_HOLD_S (HOLD_S),
        .REMIND_S    (REMIND)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_power     (btn_power),
        .btn_clean     (btn_clean),
        .fan_active    (fan_active),
        .clean_done    (clean_done),
        .is_on         (is_on),
        .start_clean   (start_clean),
        .clean_finished(clean_finished),
        .remind        (remind),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Spec-level outcome of a debounced press given the state it lands in.
    function automatic int after_press(input int s, input bit p, input bit c, input bit fan);
        if (p) return (s == 0) ? 1 : 0;
        if (c && s == 1 && !fan) return 2;
        return s;
    endfunction

    task automatic chk_state(input string tag, input int s);
        chk({tag, ".state"}, 32'(state), 32'(s));
        chk({tag, ".is_on"}, 32'(is_on), 32'(s != 0));
        chk({tag, ".start_clean"}, 32'(start_clean), 32'(s == 2));
        chk({tag, ".clean_finished"}, 32'(clean_finished), 32'(s == 3));
    endtask

    task automatic press(input bit p, input bit c, input int len);
        btn_power = p;
        btn_clean = c;
        cyc(len);
        btn_power = 1'b0;
        btn_clean = 1'b0;
        cyc(10);
    endtask

    task automatic done_pulse();
        clean_done = 1'b1;
        cyc(1);
        clean_done = 1'b0;
    endtask

    initial begin
        int n;
        int op;
        int len;
        rst        = 1'b0;
        btn_power  = 1'b0;
        btn_clean  = 1'b0;
        fan_active = 1'b0;
        clean_done = 1'b0;
        cyc(3);
        chk_state("reset", 0);
        chk("reset.remind", 32'(remind), 0);
        rst = 1'b1;
        cyc(5);
        chk_state("post_reset", 0);

        // Short glitch is rejected.
        press(1'b1, 1'b0, 2);
        chk_state("glitch", 0);

        // Power held 10 cycles: measure press-to-on latency.
        btn_power = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            n++;
            if (is_on) break;
        end
        chk("pwr_latency_in_window", 32'(n >= 5 && n <= 7), 1);
        lat = n;
        if (n < 10) cyc(10 - n);
        btn_power = 1'b0;
        cyc(10);
        m_st = 1;
        chk_state("power_on", m_st);

        // Clean cycle: FINISH held exactly HOLD_CYC cycles, then ON.
        press(1'b0, 1'b1, $urandom_range(6, 10));
        chk_state("enter_clean", 2);
        done_pulse();
        n = 0;
        if (clean_finished) n = 1;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (!clean_finished) break;
            n++;
        end
        chk("finish_len", 32'(n), 32'(HOLD_CYC));
        chk_state("finish_return", 1);

        // Abort CLEAN with power: is_on and start_clean drop together.
        press(1'b0, 1'b1, 8);
        chk_state("clean2", 2);
        btn_power = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (state != 2'd2) break;
        end
        chk_state("abort_same_cycle", 0);
        btn_power = 1'b0;
        cyc(10);
        done_pulse();
        cyc(3);
        chk_state("done_after_abort", 0);

        // Usage: 3 ticks no remind, 6 ticks saturates at REMIND.
        press(1'b1, 1'b0, 8);
        chk_state("on_for_usage", 1);
        fan_active = 1'b1;
        cyc(30);
        chk("remind_early", 32'(remind), 0);
        cyc(30);
        chk("remind_set", 32'(remind), 1);
        cyc(25);
        chk("remind_saturates", 32'(remind), 1);
        press(1'b0, 1'b1, 8);
        chk_state("clean_ignored_fan", 1);

        // clean_done coincident with power pulse in CLEAN: OFF, usage kept.
        fan_active = 1'b0;
        press(1'b0, 1'b1, 8);
        chk_state("clean3", 2);
        btn_power = 1'b1;
        cyc(lat - 1);
        clean_done = 1'b1;
        cyc(1);
        clean_done = 1'b0;
        cyc(10);
        btn_power = 1'b0;
        cyc(10);
        chk_state("done_vs_power", 0);
        chk("remind_kept_on_abort", 32'(remind), 1);

        // Full clean cycle clears the reminder.
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 8);
        chk_state("clean4", 2);
        done_pulse();
        cyc(2);
        chk_state("finish4", 3);
        chk("remind_cleared", 32'(remind), 0);
        cyc(25);
        chk_state("finish4_return", 1);

        // Simultaneous presses from ON: power wins.
        press(1'b1, 1'b1, 8);
        chk_state("both_from_on", 0);
        m_st = 0;

        // Randomised operation sequence against the spec model.
        for (int k = 0; k < 40; k++) begin
            op  = $urandom_range(0, 5);
            len = $urandom_range(6, 12);
            fan_active = 1'($urandom_range(0, 1));
            case (op)
                0: begin press(1'b1, 1'b0, len); m_st = after_press(m_st, 1, 0, fan_active); end
                1: begin press(1'b0, 1'b1, len); m_st = after_press(m_st, 0, 1, fan_active); end
                2: begin press(1'b1, 1'b1, len); m_st = after_press(m_st, 1, 1, fan_active); end
                3: begin
                    if ($urandom_range(0, 1) == 1) press(1'b1, 1'b0, $urandom_range(1, 3));
                    else press(1'b0, 1'b1, $urandom_range(1, 3));
                end
                4: begin
                    done_pulse();
                    cyc(2);
                    if (m_st == 2) begin
                        chk_state("rnd_finish", 3);
                        if ($urandom_range(0, 1) == 1) begin
                            cyc(HOLD_CYC + 5);
                            m_st = 1;
                        end else begin
                            press(1'b1, 1'b0, 7);
                            m_st = 0;
                        end
                    end
                end
                default: cyc($urandom_range(1, 20));
            endcase
            chk_state("rnd", m_st);
        end

        // Asynchronous reset in CLEAN.
        fan_active = 1'b0;
        if (m_st == 0) press(1'b1, 1'b0, 8);
        if (state != 2'd1) cyc(HOLD_CYC + 5);
        press(1'b0, 1'b1, 8);
        chk_state("pre_rst_clean", 2);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_state("async_rst", 0);
        chk("async_rst.remind", 32'(remind), 0);
        cyc(3);
        rst = 1'b1;
        cyc(15);
        chk_state("after_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
